spi_frame_ctrl: RTL and testbench
=================================

// Module: spi_frame_ctrl
// PURPOSE
//  Command/frame sequencer between the byte-level SPI slave and the on-chip image buffer.
//  - Decodes each chip-select frame as: opcode, optional 16-bit address, then a data stream.
//  - Drives buffer read/write strobes with an auto-incrementing address.
//  - Stages the response byte the SPI slave shifts out on the next transfer.
// PARAMETERS
//  ADDR_W   16     buffer address width (<=16); upper address bits beyond ADDR_W are ignored
//  DEPTH    65536  buffer depth in bytes; address wraps DEPTH-1 -> 0
//  DEV_ID   8'hA5  byte returned by the ID command
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  i_ss         in   1       chip select, active-low, already synchronised to clk
//  i_rx_valid   in   1       one-cycle pulse: i_rx_byte holds a completed MOSI byte
//  i_rx_byte    in   8       received byte
//  o_tx_byte    out  8       byte the slave loads for the next MISO transfer
//  o_mem_addr   out  ADDR_W  buffer address
//  o_mem_wdata  out  8       buffer write data
//  o_mem_we     out  1       one-cycle write strobe
//  o_mem_re     out  1       one-cycle read strobe; i_mem_rdata valid exactly 1 cycle later
//  i_mem_rdata  in   8       buffer read data
//  o_busy       out  1       high while a frame is open (i_ss low)
//  o_cmd_err    out  1       sticky: unknown opcode seen; cleared by STATUS read or reset
// BEHAVIOUR
//  Reset: state=IDLE; o_tx_byte=8'h00; o_mem_addr=0; o_mem_wdata=0.
//   o_mem_we=o_mem_re=0; o_busy=0; o_cmd_err=0; wrap flag=0.
//  Opcodes (first byte of frame):
//   8'h01 WRITE  -> ADDR_H, ADDR_L, WR_DATA
//   8'h02 READ   -> ADDR_H, ADDR_L, RD_DATA
//   8'h03 STATUS -> DISCARD
//   8'h9F ID     -> DISCARD
//   other        -> set o_cmd_err, DISCARD
//  States: IDLE, ADDR_H, ADDR_L, WR_DATA, RD_DATA, DISCARD; all advance only on i_rx_valid.
//  i_ss high at any cycle:
//   - state -> IDLE next cycle, o_busy=0, no strobe issued that cycle.
//   - Any in-flight read result is dropped; o_tx_byte -> 8'h00.
//   - Mid-frame abort is legal and leaves the buffer consistent.
//  IDLE:
//   - On any byte, o_tx_byte for the following transfer is loaded the next cycle:
//     STATUS {o_cmd_err,wrap,6'b0}; ID DEV_ID; others 8'h00.
//   - STATUS read clears o_cmd_err and wrap in that same cycle.
//  ADDR_H: latch high byte.
//  ADDR_L:
//   - Latch low byte; o_mem_addr = {hi,lo}[ADDR_W-1:0] next cycle.
//   - READ: issue o_mem_re that same next cycle (prefetch); rdata registered into
//     o_tx_byte 2 cycles after the ADDR_L i_rx_valid.
//   - The master clocks one dummy byte (its response is the prefetched data).
//  WR_DATA:
//   - Each i_rx_valid: next cycle o_mem_wdata=byte, o_mem_we=1 at the current address;
//     address increments the cycle after the strobe.
//  RD_DATA:
//   - Each i_rx_valid marks consumption of o_tx_byte: address increments, o_mem_re pulses
//     1 cycle later, new data in o_tx_byte 2 cycles after.
//   - Requirement: i_rx_valid spacing >=4 clk (always true for SCK <= clk/8).
//  Wrap: increment from DEPTH-1 gives 0 and sets the sticky wrap flag.
//  we and re are never high together; at most one strobe per received byte.
//  DISCARD: ignore bytes, o_tx_byte=8'h00 after the first response, until i_ss high.
//  i_rx_valid while i_ss high is ignored.
// TESTING
//  1 Reset then idle: all outputs at reset values; o_busy=0 while i_ss=1.
//  2 Write: ss low, bytes 01,00,10,AA,BB,CC, ss high -> we strobes: AA@0x0010, BB@0x0011,
//    CC@0x0012; o_busy falls 1 cycle after ss.
//  3 Read-back: frame 02,00,10,00,00,00 -> MISO bytes from the 4th transfer onward = AA,BB,CC;
//    exactly 3 re strobes for the 3 data bytes.
//  4 Status/ID: frame 55 -> o_cmd_err=1; frame 03,00 -> 2nd MISO byte 8'h80, o_cmd_err=0 after;
//    frame 9F,00 -> 2nd MISO byte A5.
//  5 Wrap: write at 0xFFFF with bytes 11,22 -> 11@0xFFFF, 22@0x0000; STATUS returns 8'h40.
//  6 Abort: ss high after 01,00 (mid address) -> no we; next frame 02,00,10,00,00 reads AA
//    normally; async rst_n low mid-WR_DATA -> immediate reset values, no strobe.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - SPI command/frame sequencer in front of the image buffer
module spi_frame_ctrl #(
  parameter int          ADDR_W = 16,
  parameter int          DEPTH  = 65536,
  parameter logic [7:0]  DEV_ID = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_byte,
  output logic [7:0]        o_tx_byte,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_busy,
  output logic              o_cmd_err
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_H  = 3'd1;
  localparam logic [2:0] ST_ADDR_L  = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DISCARD = 3'd5;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_ID     = 8'h9F;

  logic [2:0]        state_q, state_d;
  logic              is_rd_q, is_rd_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic              rd_pend_q, rd_pend_d;
  logic [7:0]        tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;
  logic              wrap_q, wrap_d;

  logic [15:0]       full_addr;
  logic              wrap_hit;
  logic [ADDR_W-1:0] addr_inc;

  assign full_addr = {addr_hi_q, i_rx_byte};

  always_comb begin
    wrap_hit = (addr_q == ADDR_W'(DEPTH - 1));
    addr_inc = wrap_hit ? '0 : addr_q + ADDR_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    is_rd_d   = is_rd_q;
    addr_hi_d = addr_hi_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    re_d      = 1'b0;
    rd_pend_d = re_q;
    tx_d      = tx_q;
    busy_d    = ~i_ss;
    cmd_err_d = cmd_err_q;
    wrap_d    = wrap_q;

    // Write address advances the cycle after its strobe.
    if (we_q) begin
      addr_d = addr_inc;
      if (wrap_hit) wrap_d = 1'b1;
    end

    if (rd_pend_q) tx_d = i_mem_rdata;

    if (i_ss) begin
      state_d   = ST_IDLE;
      rd_pend_d = 1'b0;
      tx_d      = 8'h00;
    end else if (i_rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          tx_d = 8'h00;
          case (i_rx_byte)
            OP_WRITE: begin
              is_rd_d = 1'b0;
              state_d = ST_ADDR_H;
            end
            OP_READ: begin
              is_rd_d = 1'b1;
              state_d = ST_ADDR_H;
            end
            OP_STATUS: begin
              tx_d      = {cmd_err_q, wrap_q, 6'b0};
              cmd_err_d = 1'b0;
              wrap_d    = 1'b0;
              state_d   = ST_DISCARD;
            end
            OP_ID: begin
              tx_d    = DEV_ID;
              state_d = ST_DISCARD;
            end
            default: begin
              cmd_err_d = 1'b1;
              state_d   = ST_DISCARD;
            end
          endcase
        end
        ST_ADDR_H: begin
          addr_hi_d = i_rx_byte;
          tx_d      = 8'h00;
          state_d   = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d = full_addr[ADDR_W-1:0];
          tx_d   = 8'h00;
          if (is_rd_q) begin
            re_d    = 1'b1;
            state_d = ST_RD_DATA;
          end else begin
            state_d = ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          wdata_d = i_rx_byte;
          we_d    = 1'b1;
        end
        ST_RD_DATA: begin
          // Byte consumed: fetch the next location for the following transfer.
          addr_d = addr_inc;
          if (wrap_hit) wrap_d = 1'b1;
          re_d = 1'b1;
        end
        ST_DISCARD: tx_d = 8'h00;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      is_rd_q   <= 1'b0;
      addr_hi_q <= 8'h00;
      addr_q    <= '0;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      tx_q      <= 8'h00;
      busy_q    <= 1'b0;
      cmd_err_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_rd_q   <= is_rd_d;
      addr_hi_q <= addr_hi_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      rd_pend_q <= rd_pend_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cmd_err_q <= cmd_err_d;
      wrap_q    <= wrap_d;
    end
  end

  assign o_tx_byte   = tx_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = we_q;
  assign o_mem_re    = re_q;
  assign o_busy      = busy_q;
  assign o_cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - directed and random frame checks against a byte-level frame model
module tb_spi_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_ss = 1'b1;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_byte = 8'h00;
  logic [7:0]  o_tx_byte;
  logic [15:0] o_mem_addr;
  logic [7:0]  o_mem_wdata;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [7:0]  i_mem_rdata = 8'h00;
  logic        o_busy;
  logic        o_cmd_err;

  spi_frame_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ss        (i_ss),
    .i_rx_valid  (i_rx_valid),
    .i_rx_byte   (i_rx_byte),
    .o_tx_byte   (o_tx_byte),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_we    (o_mem_we),
    .o_mem_re    (o_mem_re),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_cmd_err   (o_cmd_err)
  );

  always #5 clk = ~clk;

  logic [7:0]  tb_mem  [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        ref_err  = 1'b0;
  logic        ref_wrap = 1'b0;
  logic        overlap  = 1'b0;

  logic [23:0] wr_log[$];
  logic [15:0] rd_log[$];
  logic [7:0]  obs_miso[$];
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_miso[$];

  int errors = 0;
  int checks = 0;

  always @(posedge clk) begin
    if (o_mem_we) tb_mem[o_mem_addr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= tb_mem[o_mem_addr];
  end

  always @(negedge clk) begin
    if (o_mem_we && o_mem_re) overlap = 1'b1;
    if (o_mem_we) wr_log.push_back({o_mem_addr, o_mem_wdata});
    if (o_mem_re) rd_log.push_back(o_mem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: what the master sees on MISO and what lands in the buffer.
  task automatic model_frame(input logic [7:0] b[$]);
    int n;
    int a;
    n = b.size();
    exp_miso.delete();
    exp_wr.delete();
    exp_rd.delete();
    for (int i = 0; i < n; i++) exp_miso.push_back(8'h00);
    if (n == 0) return;
    case (b[0])
      8'h01: if (n >= 3) begin
        a = {b[1], b[2]};
        for (int i = 3; i < n; i++) begin
          exp_wr.push_back({a[15:0], b[i]});
          ref_mem[a] = b[i];
          if (a == 65535) ref_wrap = 1'b1;
          a = (a + 1) % 65536;
        end
      end
      8'h02: if (n >= 3) begin
        a = {b[1], b[2]};
        exp_rd.push_back(a[15:0]);
        for (int i = 3; i < n; i++) begin
          exp_miso[i] = ref_mem[a];
          if (a == 65535) ref_wrap = 1'b1;
          a = (a + 1) % 65536;
          exp_rd.push_back(a[15:0]);
        end
      end
      8'h03: begin
        if (n >= 2) exp_miso[1] = {ref_err, ref_wrap, 6'b0};
        ref_err  = 1'b0;
        ref_wrap = 1'b0;
      end
      8'h9F: if (n >= 2) exp_miso[1] = 8'hA5;
      default: ref_err = 1'b1;
    endcase
  endtask

  task automatic xfer(input logic [7:0] b);
    obs_miso.push_back(o_tx_byte);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(negedge clk);
    i_rx_valid = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b[$], input string tag);
    wr_log.delete();
    rd_log.delete();
    obs_miso.delete();
    model_frame(b);
    i_ss = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_busy_hi"}, o_busy, 1'b1);
    foreach (b[i]) xfer(b[i]);
    i_ss = 1'b1;
    @(negedge clk);
    check({tag, "_busy_lo"}, o_busy, 1'b0);
    repeat (2) @(negedge clk);
    foreach (exp_miso[i]) check($sformatf("%s_miso%0d", tag, i), obs_miso[i], exp_miso[i]);
    check({tag, "_nwr"}, wr_log.size(), exp_wr.size());
    foreach (exp_wr[i]) check($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_wr[i]);
    check({tag, "_nrd"}, rd_log.size(), exp_rd.size());
    foreach (exp_rd[i]) check($sformatf("%s_rd%0d", tag, i), rd_log[i], exp_rd[i]);
    check({tag, "_err"}, o_cmd_err, ref_err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx"},    o_tx_byte,   8'h00);
    check({tag, "_addr"},  o_mem_addr,  16'h0000);
    check({tag, "_wdata"}, o_mem_wdata, 8'h00);
    check({tag, "_we"},    o_mem_we,    1'b0);
    check({tag, "_re"},    o_mem_re,    1'b0);
    check({tag, "_busy"},  o_busy,      1'b0);
    check({tag, "_err"},   o_cmd_err,   1'b0);
  endtask

  initial begin
    logic [7:0] fr[$];
    int         hits;
    int         r;
    int         nd;
    logic [7:0] op;
    logic [15:0] ad;

    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = 8'h00;
      ref_mem[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("idle");

    fr = '{8'h01, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    run_frame(fr, "write");
    check("write_n", wr_log.size(), 3);
    check("write_aa", wr_log[0], {16'h0010, 8'hAA});
    check("write_cc", wr_log[2], {16'h0012, 8'hCC});

    fr = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
    run_frame(fr, "read");
    check("read_m3", obs_miso[3], 8'hAA);
    check("read_m4", obs_miso[4], 8'hBB);
    check("read_m5", obs_miso[5], 8'hCC);
    hits = 0;
    foreach (rd_log[i]) if (rd_log[i] >= 16'h0010 && rd_log[i] <= 16'h0012) hits++;
    check("read_re_data", hits, 3);

    fr = '{8'h55};
    run_frame(fr, "badop");
    check("badop_err", o_cmd_err, 1'b1);
    fr = '{8'h03, 8'h00};
    run_frame(fr, "status1");
    check("status1_byte", obs_miso[1], 8'h80);
    check("status1_clr", o_cmd_err, 1'b0);
    fr = '{8'h9F, 8'h00};
    run_frame(fr, "id");
    check("id_byte", obs_miso[1], 8'hA5);

    fr = '{8'h01, 8'hFF, 8'hFF, 8'h11, 8'h22};
    run_frame(fr, "wrap");
    check("wrap_11", wr_log[0], {16'hFFFF, 8'h11});
    check("wrap_22", wr_log[1], {16'h0000, 8'h22});
    fr = '{8'h03, 8'h00};
    run_frame(fr, "status2");
    check("status2_byte", obs_miso[1], 8'h40);

    fr = '{8'h01, 8'h00};
    run_frame(fr, "abort");
    check("abort_nowe", wr_log.size(), 0);
    fr = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00};
    run_frame(fr, "after_abort");
    check("after_abort_m3", obs_miso[3], 8'hAA);

    wr_log.delete();
    i_ss = 1'b0;
    repeat (2) @(negedge clk);
    xfer(8'h01);
    xfer(8'h00);
    xfer(8'h20);
    i_rx_byte  = 8'h77;
    i_rx_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check("async_rst_nowe", o_mem_we, 1'b0);
    @(negedge clk);
    i_rx_valid = 1'b0;
    i_ss = 1'b1;
    check("async_rst_nolog", wr_log.size(), 0);
    ref_err  = 1'b0;
    ref_wrap = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 24; k++) begin
      fr.delete();
      r = $urandom_range(0, 9);
      if (r < 3)       op = 8'h01;
      else if (r < 6)  op = 8'h02;
      else if (r == 6) op = 8'h03;
      else if (r == 7) op = 8'h9F;
      else             op = {4'hC, 4'($urandom_range(0, 15))};
      fr.push_back(op);
      if (op == 8'h01 || op == 8'h02) begin
        if ($urandom_range(0, 3) == 0) ad = 16'hFFFD + 16'($urandom_range(0, 2));
        else                           ad = 16'h0100 + 16'($urandom_range(0, 7));
        fr.push_back(ad[15:8]);
        fr.push_back(ad[7:0]);
        nd = $urandom_range(0, 4);
        for (int j = 0; j < nd; j++) fr.push_back(8'($urandom_range(0, 255)));
        if ($urandom_range(0, 4) == 0) begin
          nd = $urandom_range(1, fr.size());
          while (fr.size() > nd) void'(fr.pop_back());
        end
      end else begin
        nd = $urandom_range(0, 2);
        for (int j = 0; j < nd; j++) fr.push_back(8'($urandom_range(0, 255)));
      end
      run_frame(fr, $sformatf("rnd%0d", k));
    end

    check("no_we_re_overlap", overlap, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
